// File: rtl/gray_pkg.sv
// Shared types and max-width Gray/binary conversions for the
// Gray counter slice; callers cast results down to their own width.
package gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {DIR_DOWN, DIR_UP} dir_e;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(
        input logic [MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave it exact.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(
        input logic [MAX_WIDTH-1:0] g
    );
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_ud_if.sv
// Control/status bundle of the Gray up/down counter.
// QBIN exists only when GRAY_CNT_BIN_OUT_EN is defined.
interface gray_counter_ud_if #(
    parameter int unsigned width = 8
);

    logic             EN;
    logic             UP;
    logic             LD;
    logic [width-1:0] D;
    logic [width-1:0] Q;
    logic             TC;
    logic             OVF;

`ifdef GRAY_CNT_BIN_OUT_EN
    logic [width-1:0] QBIN;

    modport master (
        output EN, UP, LD, D,
        input  Q, TC, OVF, QBIN
    );

    modport slave (
        input  EN, UP, LD, D,
        output Q, TC, OVF, QBIN
    );
`else
    modport master (
        output EN, UP, LD, D,
        input  Q, TC, OVF
    );

    modport slave (
        input  EN, UP, LD, D,
        output Q, TC, OVF
    );
`endif

endinterface

// File: rtl/gray_step.sv
// Combinational one-step Gray increment/decrement using the
// parity rule, plus a boundary flag for the chosen direction.
module gray_step #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] A,
    input  logic             UP,
    input  logic             CI,
    output logic [width-1:0] Z,
    output logic             BND
);

    localparam logic [width-1:0] MSB =
        {1'b1, {(width-1){1'b0}}};

    logic             par;
    logic [width-1:0] low;
    logic [width-1:0] left;
    logic [width-1:0] flip;

    always_comb begin
        par  = ^A;
        low  = A & (~A + width'(1));
        left = low << 1;
        // No set bit, or lowest set bit is the MSB: flip the MSB.
        if (left == '0)
            left = MSB;
        flip = (par ^ ~UP) ? left : width'(1);
        Z    = CI ? (A ^ flip) : A;
        BND  = UP ? (A == MSB) : (A == '0);
    end

endmodule

// File: rtl/gray_counter_ud.sv
// Registered Gray up/down counter with load, wrap/saturate and flags.
// Define GRAY_CNT_BIN_OUT_EN to add the registered binary output QBIN.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int unsigned          width   = 8,
    parameter bit                   WRAP    = 1'b1,
    parameter logic [MAX_WIDTH-1:0] RST_VAL = '0
) (
    input logic              CLK,
    input logic              RST,
    gray_counter_ud_if.slave bus
);

    localparam logic [width-1:0] RST_Q =
        width'(bin2gray(RST_VAL));

    dir_e             dir;
    logic [width-1:0] q_r;
    logic [width-1:0] step_z;
    logic [width-1:0] q_nxt;
    logic [width-1:0] q_run;
    logic             bnd;
    logic             ovf_r;

    assign dir = bus.UP ? DIR_UP : DIR_DOWN;

    gray_step #(
        .width(width)
    ) u_step (
        .A   (q_r),
        .UP  (dir == DIR_UP),
        .CI  (bus.EN),
        .Z   (step_z),
        .BND (bnd)
    );

    // Saturating mode parks on the boundary instead of wrapping.
    assign q_nxt = (bnd && !WRAP) ? q_r : step_z;
    assign q_run = bus.LD ? bus.D : q_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r   <= RST_Q;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_run;
            ovf_r <= !bus.LD && bus.EN && bnd;
        end
    end

    assign bus.Q   = q_r;
    assign bus.TC  = bnd;
    assign bus.OVF = ovf_r;

`ifdef GRAY_CNT_BIN_OUT_EN
    localparam logic [width-1:0] RST_B = width'(RST_VAL);

    logic [width-1:0] qbin_r;

    always_ff @(posedge CLK) begin
        if (RST)
            qbin_r <= RST_B;
        else
            qbin_r <= width'(gray2bin(MAX_WIDTH'(q_run)));
    end

    assign bus.QBIN = qbin_r;
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: directed scenarios on width 4 and a
// random walk on widths 2 and 32 against a binary counter model.
module tb_gray_counter_ud;

    localparam logic [31:0] RV2  = 32'd2;
    localparam logic [31:0] RV32 = 32'hFFFF_FFFD;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gray_counter_ud_if #(.width(4))  if4w ();
    gray_counter_ud_if #(.width(4))  if4s ();
    gray_counter_ud_if #(.width(2))  if2 ();
    gray_counter_ud_if #(.width(32)) if32 ();

    gray_counter_ud #(.width(4), .WRAP(1'b1), .RST_VAL(32'd0))
        u_w (.CLK(clk), .RST(rst), .bus(if4w));
    gray_counter_ud #(.width(4), .WRAP(1'b0), .RST_VAL(32'd0))
        u_s (.CLK(clk), .RST(rst), .bus(if4s));
    gray_counter_ud #(.width(2), .WRAP(1'b1), .RST_VAL(RV2))
        u_2 (.CLK(clk), .RST(rst), .bus(if2));
    gray_counter_ud #(.width(32), .WRAP(1'b0), .RST_VAL(RV32))
        u_32 (.CLK(clk), .RST(rst), .bus(if32));

    function automatic longint unsigned gray_of(input longint unsigned b);
        return b ^ (b >> 1);
    endfunction

    // Reference: plain binary counter with wrap or saturate.
    function automatic longint unsigned mstep(
        input longint unsigned b, input bit up, input bit wrap,
        input int w, output bit ovf);
        longint unsigned mx;
        mx  = (64'd1 << w) - 1;
        ovf = up ? (b == mx) : (b == 0);
        if (!ovf) return up ? b + 1 : b - 1;
        if (!wrap) return b;
        return up ? 0 : mx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if4w.EN = 0; if4w.UP = 0; if4w.LD = 0; if4w.D = '0;
        if4s.EN = 0; if4s.UP = 0; if4s.LD = 0; if4s.D = '0;
        if2.EN  = 0; if2.UP  = 0; if2.LD  = 0; if2.D  = '0;
        if32.EN = 0; if32.UP = 0; if32.LD = 0; if32.D = '0;
    endtask

    task automatic test_reset();
        idle_all();
        if4w.EN = 1; if4w.UP = 1;
        rst = 1;
        tick();
        rst = 0;
        if4w.EN = 0;
        n_cmp++; if (if4w.Q !== 4'b0000) begin n_bad++;
            $display("FAIL reset_q got %b want 0000", if4w.Q); end
        n_cmp++; if (if4w.OVF !== 1'b0) begin n_bad++;
            $display("FAIL reset_ovf got %b want 0", if4w.OVF); end
        n_cmp++; if (if4w.TC !== 1'b0) begin n_bad++;
            $display("FAIL reset_tc got %b want 0", if4w.TC); end
        n_cmp++; if (if2.Q !== 2'(gray_of(RV2))) begin n_bad++;
            $display("FAIL reset_q2 got %b want %b", if2.Q, 2'(gray_of(RV2))); end
        n_cmp++; if (if32.Q !== 32'(gray_of(RV32))) begin n_bad++;
            $display("FAIL reset_q32 got %h want %h", if32.Q, 32'(gray_of(RV32))); end
`ifdef GRAY_CNT_BIN_OUT_EN
        n_cmp++; if (if32.QBIN !== RV32) begin n_bad++;
            $display("FAIL reset_qbin got %h want %h", if32.QBIN, RV32); end
`endif
    endtask

    task automatic test_count_up();
        logic [3:0] prev;
        longint unsigned b = 0;
        if4w.EN = 1; if4w.UP = 1;
        for (int i = 1; i <= 15; i++) begin
            prev = if4w.Q;
            tick();
            b++;
            n_cmp++; if (if4w.Q !== 4'(gray_of(b))) begin n_bad++;
                $display("FAIL up_q step %0d got %b want %b", i, if4w.Q, 4'(gray_of(b))); end
            n_cmp++; if ($countones(prev ^ if4w.Q) != 1) begin n_bad++;
                $display("FAIL up_hamming step %0d got %b want 1-bit change from %b", i, if4w.Q, prev); end
            n_cmp++; if (if4w.TC !== (b == 15)) begin n_bad++;
                $display("FAIL up_tc step %0d got %b want %b", i, if4w.TC, b == 15); end
            n_cmp++; if (if4w.OVF !== 1'b0) begin n_bad++;
                $display("FAIL up_ovf step %0d got %b want 0", i, if4w.OVF); end
`ifdef GRAY_CNT_BIN_OUT_EN
            n_cmp++; if (if4w.QBIN !== 4'(b)) begin n_bad++;
                $display("FAIL up_qbin step %0d got %0d want %0d", i, if4w.QBIN, b); end
`endif
        end
    endtask

    task automatic test_wrap();
        longint unsigned b = 15;
        bit o;
        bit ups [3] = '{1'b1, 1'b0, 1'b0};
        bit ens [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            if4w.UP = ups[i]; if4w.EN = ens[i];
            tick();
            if (ens[i]) b = mstep(b, ups[i], 1'b1, 4, o);
            else o = 0;
            n_cmp++; if (if4w.Q !== 4'(gray_of(b))) begin n_bad++;
                $display("FAIL wrap_q %0d got %b want %b", i, if4w.Q, 4'(gray_of(b))); end
            n_cmp++; if (if4w.OVF !== o) begin n_bad++;
                $display("FAIL wrap_ovf %0d got %b want %b", i, if4w.OVF, o); end
        end
    endtask

    task automatic test_saturate();
        if4s.LD = 1; if4s.D = 4'b1000;
        tick();
        if4s.LD = 0; if4s.EN = 1; if4s.UP = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if4s.Q !== 4'b1000 || if4s.OVF !== 1'b1) begin n_bad++;
                $display("FAIL sat_max %0d got Q=%b OVF=%b want 1000/1", i, if4s.Q, if4s.OVF); end
        end
        if4s.UP = 0;
        tick();
        n_cmp++; if (if4s.Q !== 4'b1001 || if4s.OVF !== 1'b0) begin n_bad++;
            $display("FAIL sat_down got Q=%b OVF=%b want 1001/0", if4s.Q, if4s.OVF); end
        if4s.LD = 1; if4s.D = 4'b0000;
        tick();
        if4s.LD = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (if4s.Q !== 4'b0000 || if4s.OVF !== 1'b1) begin n_bad++;
                $display("FAIL sat_min %0d got Q=%b OVF=%b want 0000/1", i, if4s.Q, if4s.OVF); end
        end
        if4s.EN = 0;
    endtask

    task automatic test_load();
        if4w.LD = 1; if4w.D = 4'b0110; if4w.EN = 1; if4w.UP = 1;
        tick();
        if4w.LD = 0;
        n_cmp++; if (if4w.Q !== 4'b0110 || if4w.OVF !== 1'b0) begin n_bad++;
            $display("FAIL load_q got Q=%b OVF=%b want 0110/0", if4w.Q, if4w.OVF); end
`ifdef GRAY_CNT_BIN_OUT_EN
        n_cmp++; if (if4w.QBIN !== 4'd4) begin n_bad++;
            $display("FAIL load_qbin got %0d want 4", if4w.QBIN); end
`endif
        tick();
        if4w.EN = 0;
        n_cmp++; if (if4w.Q !== 4'b0111) begin n_bad++;
            $display("FAIL load_next got %b want 0111", if4w.Q); end
    endtask

    task automatic test_tc_comb();
        if4w.LD = 1; if4w.D = 4'b1000;
        tick();
        if4w.LD = 0; if4w.UP = 1;
        #1;
        n_cmp++; if (if4w.TC !== 1'b1) begin n_bad++;
            $display("FAIL tc_max_up got %b want 1", if4w.TC); end
        if4w.UP = 0;
        #1;
        n_cmp++; if (if4w.TC !== 1'b0) begin n_bad++;
            $display("FAIL tc_max_down got %b want 0", if4w.TC); end
        tick();
        n_cmp++; if (if4w.Q !== 4'b1000 || if4w.OVF !== 1'b0) begin n_bad++;
            $display("FAIL hold got Q=%b OVF=%b want 1000/0", if4w.Q, if4w.OVF); end
        if4w.LD = 1; if4w.D = 4'b0000;
        tick();
        if4w.LD = 0;
        n_cmp++; if (if4w.TC !== 1'b1) begin n_bad++;
            $display("FAIL tc_min_down got %b want 1", if4w.TC); end
        if4w.UP = 1;
        #1;
        n_cmp++; if (if4w.TC !== 1'b0) begin n_bad++;
            $display("FAIL tc_min_up got %b want 0", if4w.TC); end
    endtask

    task automatic test_reset_mid();
        if4w.LD = 1; if4w.D = 4'b0101;
        tick();
        if4w.LD = 0; if4w.EN = 1; if4w.UP = 1; rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (if4w.Q !== 4'b0000 || if4w.OVF !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid got Q=%b OVF=%b want 0000/0", if4w.Q, if4w.OVF); end
        if4w.EN = 0; if4w.LD = 1; if4w.D = 4'b1000;
        tick();
        if4w.LD = 0; if4w.EN = 1; rst = 1;
        tick();
        rst = 0; if4w.EN = 0;
        n_cmp++; if (if4w.Q !== 4'b0000 || if4w.OVF !== 1'b0) begin n_bad++;
            $display("FAIL rst_ovf got Q=%b OVF=%b want 0000/0", if4w.Q, if4w.OVF); end
    endtask

    task automatic test_random_walk();
        longint unsigned b2, b32, old2, old32, v2, v32, mx32;
        bit o2, o32, r, l2, e2, u2, l32, e32, u32;
        logic [1:0]  p2;
        logic [31:0] p32;
        mx32 = (64'd1 << 32) - 1;
        rst = 1;
        tick();
        rst = 0;
        b2 = RV2; b32 = RV32;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 29) == 0);
            l2  = ($urandom_range(0, 9) == 0);
            e2  = ($urandom_range(0, 3) != 0);
            u2  = 1'($urandom_range(0, 1));
            v2  = $urandom_range(0, 3);
            l32 = ($urandom_range(0, 9) == 0);
            e32 = ($urandom_range(0, 3) != 0);
            u32 = ($urandom_range(0, 3) != 0);
            v32 = $urandom_range(0, 1) ? mx32 - $urandom_range(0, 3)
                                       : longint'($urandom);
            rst = r;
            if2.LD = l2; if2.EN = e2; if2.UP = u2;
            if2.D = 2'(gray_of(v2));
            if32.LD = l32; if32.EN = e32; if32.UP = u32;
            if32.D = 32'(gray_of(v32));
            p2 = if2.Q; p32 = if32.Q;
            old2 = b2; old32 = b32;
            tick();
            if (r) begin b2 = RV2; o2 = 0; end
            else if (l2) begin b2 = v2; o2 = 0; end
            else if (e2) b2 = mstep(b2, u2, 1'b1, 2, o2);
            else o2 = 0;
            if (r) begin b32 = RV32; o32 = 0; end
            else if (l32) begin b32 = v32; o32 = 0; end
            else if (e32) b32 = mstep(b32, u32, 1'b0, 32, o32);
            else o32 = 0;
            n_cmp++; if (if2.Q !== 2'(gray_of(b2)) || if2.OVF !== o2) begin n_bad++;
                $display("FAIL rw2 %0d got Q=%b OVF=%b want %b/%b", i, if2.Q, if2.OVF, 2'(gray_of(b2)), o2); end
            n_cmp++; if (if2.TC !== (u2 ? b2 == 3 : b2 == 0)) begin n_bad++;
                $display("FAIL rw2_tc %0d got %b", i, if2.TC); end
            n_cmp++; if (if32.Q !== 32'(gray_of(b32)) || if32.OVF !== o32) begin n_bad++;
                $display("FAIL rw32 %0d got Q=%h OVF=%b want %h/%b", i, if32.Q, if32.OVF, 32'(gray_of(b32)), o32); end
            n_cmp++; if (if32.TC !== (u32 ? b32 == mx32 : b32 == 0)) begin n_bad++;
                $display("FAIL rw32_tc %0d got %b", i, if32.TC); end
            if (!r && !l2 && e2) begin
                n_cmp++; if ($countones(p2 ^ if2.Q) != ((b2 != old2) ? 1 : 0)) begin n_bad++;
                    $display("FAIL rw2_hamming %0d got %b from %b", i, if2.Q, p2); end
            end
            if (!r && !l32 && e32) begin
                n_cmp++; if ($countones(p32 ^ if32.Q) != ((b32 != old32) ? 1 : 0)) begin n_bad++;
                    $display("FAIL rw32_hamming %0d got %h from %h", i, if32.Q, p32); end
            end
`ifdef GRAY_CNT_BIN_OUT_EN
            n_cmp++; if (if2.QBIN !== 2'(b2) || if32.QBIN !== 32'(b32)) begin n_bad++;
                $display("FAIL rw_qbin %0d got %0d/%h want %0d/%h", i, if2.QBIN, if32.QBIN, b2, b32); end
`endif
        end
        rst = 0;
        idle_all();
    endtask

    initial begin
        rst = 0;
        idle_all();
        tick();
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_load();
        test_tc_comb();
        test_reset_mid();
        test_random_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
